fpn_multiplier: RTL and testbench
=================================

// Module: fpn_multiplier
// PURPOSE
//  Parametrised sign/exponent/mantissa floating-point multiplier with a start/done handshake.
//  Next-generation MAC datapath multiplier:
//   - configurable EXP_W/MAN_W/BIAS
//   - optional round-to-nearest-even
//   - {invalid, overflow, underflow} status flags
//  Multi-cycle FSM; one operation in flight.
// PARAMETERS
//  EXP_W  4                    exponent width (>=3)
//  MAN_W  3                    stored mantissa width, hidden bit excluded (>=2)
//  BIAS   2**(EXP_W-1)-1 (=7)  exponent bias
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          synchronous active-low reset
//  start_mul  in   1          request; sampled only in IDLE
//  a          in   1+EXP_W+MAN_W  operand A {sign, exp, man}
//  b          in   1+EXP_W+MAN_W  operand B
//  busy       out  1          high in every state except IDLE
//  done_mul   out  1          result valid; held until start_mul low
//  product    out  1+EXP_W+MAN_W  result
//  flags      out  3          {invalid, overflow, underflow}; valid with done_mul
// BEHAVIOUR
//  Reset:
//   - rst_n low at a clk edge -> state IDLE, all outputs 0, operand/work registers 0.
//   - Applies from any state; an op in flight is abandoned with no done_mul.
//  Encoding:
//   - exp==0 -> zero; subnormals flush to zero on input and output.
//   - exp all-ones, man==0 -> inf; exp all-ones, man!=0 -> NaN.
//   - Canonical NaN output = all ones.
//  States and transitions:
//   - IDLE:  start_mul=1 -> capture a,b; go to CHECK.
//   - CHECK: sign = sa^sb.
//            Special operand -> write product/flags, go to DONE.
//            Otherwise go to MUL.
//   - MUL:   sig = {1,ma}*{1,mb} (2*MAN_W+2 bits);
//            e = ea+eb-BIAS, signed, EXP_W+2 bits.
//   - NORM:  if sig MSB=1 -> e+1; m = sig[2M:M+1]; guard g = sig[M]; sticky s = |sig[M-1:0].
//            Else m = sig[2M-1:M]; g = sig[M-1]; s = |sig[M-2:0].  (M = MAN_W)
//   - ROUND: rounding step (see CONFIGURATION).
//            Mantissa carry-out -> m = 0, e+1.
//            e >= 2**EXP_W-1 -> {sign, inf}, overflow=1.
//            e <= 0 -> {sign, zero}, underflow=1.
//            Otherwise {sign, e[EXP_W-1:0], m}.
//            Write product/flags; go to DONE.
//   - DONE:  done_mul=1; product/flags held.
//            start_mul=0 -> IDLE, done_mul cleared on that edge.
//  Special-operand priority:
//   1. Any NaN -> all-ones, invalid=1.
//   2. inf*zero -> all-ones, invalid=1.
//   3. inf*finite -> {sign, inf}, no flags.
//   4. zero*any -> {sign, zero}, no flags.
//  Latency (start sampled at edge E0):
//   - Special: done_mul high after E1.
//   - Normal: done_mul high after E4.
//  Handshake:
//   - start_mul outside IDLE is ignored; a, b are don't-care after E0.
//   - start_mul held high through DONE -> stay in DONE; no new op until it drops.
//   - New op accepted on the first IDLE cycle with start_mul=1.
//   - Back-to-back ops therefore need start_mul low for >=1 cycle.
//  Outputs: product and flags are registered; they are only updated on entry to DONE.
// CONFIGURATION
//  FPN_MUL_RNE_EN defined:
//   - ROUND rounds to nearest even: increment m if g & (s | m[0]).
//   - Carry-out handled as above.
//  FPN_MUL_RNE_EN undefined:
//   - ROUND truncates; m unchanged, g and s ignored.
//   - Latency and all other behaviour are identical.
// TESTING  (defaults E4M3, BIAS=7)
//  1. a=0x38, b=0x38 (1.0*1.0) -> product=0x38, flags=000, done after 4 cycles, busy=1 meanwhile.
//  2. a=0x3C, b=0x3C (1.5*1.5) -> product=0x41 (2.25), normalise shift taken, flags=000.
//  3. a=0x3D, b=0x3D (1.625^2) -> product=0x43 with FPN_MUL_RNE_EN; 0x42 without.
//  4. Overflow:
//     - a=0x70, b=0x70 -> 0x78, overflow=1.
//     - a=0xF0, b=0x70 -> 0xF8.
//     - a=0x08, b=0x08 -> 0x00, underflow=1.
//     - a=0x88, b=0x08 -> 0x80.
//  5. Special (each with done after 1 cycle):
//     - a=0x78, b=0x00 -> 0xFF, invalid=1.
//     - a=0x79, b=0x38 -> 0xFF, invalid=1.
//     - a=0x78, b=0xB8 -> 0xF8.
//  6. Handshake and reset:
//     - start_mul held high 10 cycles -> done_mul stays 1, product stable, single op.
//     - rst_n=0 for one edge while in MUL -> done_mul=0, product=0, busy=0; next op correct.

Source files
------------

// File: rtl/fpn_multiplier.sv
// Multi-cycle sign/exponent/mantissa floating-point multiplier with a start/done handshake.
// Define FPN_MUL_RNE_EN to round to nearest even. Without it the result is truncated.
module fpn_multiplier #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int BIAS  = 2**(EXP_W-1)-1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_mul,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     busy,
    output logic                     done_mul,
    output logic [EXP_W+MAN_W:0]     product,
    output logic [2:0]               flags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = 2*MAN_W + 2;
    localparam int E_W   = EXP_W + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_MUL, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [E_W-1:0]     e_q, e_d;
    logic [MAN_W-1:0]   m_q, m_d;
    logic               g_q, g_d, s_q, s_d;
    logic [W-1:0]       prod_q, prod_d;
    logic [2:0]         flags_q, flags_d;

    logic               sa, sb, sign_ab;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   ma, mb;
    logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    assign {sa, ea, ma} = a_q;
    assign {sb, eb, mb} = b_q;
    assign sign_ab = sa ^ sb;

    // Exponent zero covers subnormals too: they are flushed to zero.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (ma == '0);
    assign b_inf  = (&eb) && (mb == '0);
    assign a_nan  = (&ea) && (ma != '0);
    assign b_nan  = (&eb) && (mb != '0);

    logic               rnd_inc;
    logic [MAN_W:0]     m_rnd;
    logic [E_W-1:0]     e_rnd;
    logic [MAN_W-1:0]   m_out;
    logic               ovf, unf;

`ifdef FPN_MUL_RNE_EN
    assign rnd_inc = g_q & (s_q | m_q[0]);
`else
    logic unused_rnd;
    assign rnd_inc    = 1'b0;
    assign unused_rnd = &{1'b0, g_q, s_q};
`endif

    // e_rnd is two's complement; test the sign bit explicitly instead of signed compares.
    assign m_rnd = {1'b0, m_q} + (MAN_W+1)'(rnd_inc);
    assign e_rnd = m_rnd[MAN_W] ? e_q + E_W'(1) : e_q;
    assign m_out = m_rnd[MAN_W] ? '0 : m_rnd[MAN_W-1:0];
    assign ovf   = !e_rnd[E_W-1] && (e_rnd >= E_W'(2**EXP_W - 1));
    assign unf   = e_rnd[E_W-1] || (e_rnd == '0);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        sig_d   = sig_q;
        e_d     = e_q;
        m_d     = m_q;
        g_d     = g_q;
        s_d     = s_q;
        prod_d  = prod_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (start_mul) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                sign_d  = sign_ab;
                state_d = S_DONE;
                if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
                    prod_d  = '1;
                    flags_d = 3'b100;
                end else if (a_inf || b_inf) begin
                    prod_d  = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d = 3'b000;
                end else if (a_zero || b_zero) begin
                    prod_d  = {sign_ab, {(W-1){1'b0}}};
                    flags_d = 3'b000;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                sig_d   = SIG_W'({1'b1, ma}) * SIG_W'({1'b1, mb});
                e_d     = E_W'(ea) + E_W'(eb) - E_W'(BIAS);
                state_d = S_NORM;
            end
            S_NORM: begin
                if (sig_q[SIG_W-1]) begin
                    e_d = e_q + E_W'(1);
                    m_d = sig_q[2*MAN_W:MAN_W+1];
                    g_d = sig_q[MAN_W];
                    s_d = |sig_q[MAN_W-1:0];
                end else begin
                    m_d = sig_q[2*MAN_W-1:MAN_W];
                    g_d = sig_q[MAN_W-1];
                    s_d = |sig_q[MAN_W-2:0];
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (ovf) begin
                    prod_d  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d = 3'b010;
                end else if (unf) begin
                    prod_d  = {sign_q, {(W-1){1'b0}}};
                    flags_d = 3'b001;
                end else begin
                    prod_d  = {sign_q, e_rnd[EXP_W-1:0], m_out};
                    flags_d = 3'b000;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!start_mul) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            sig_q   <= '0;
            e_q     <= '0;
            m_q     <= '0;
            g_q     <= 1'b0;
            s_q     <= 1'b0;
            prod_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            sig_q   <= sig_d;
            e_q     <= e_d;
            m_q     <= m_d;
            g_q     <= g_d;
            s_q     <= s_d;
            prod_q  <= prod_d;
            flags_q <= flags_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done_mul = (state_q == S_DONE);
    assign product  = prod_q;
    assign flags    = flags_q;

endmodule

// File: tb/tb_fpn_multiplier.sv
// Self-checking bench for fpn_multiplier (E4M3 defaults): vector table plus handshake/reset sequences.
// Expected results follow FPN_MUL_RNE_EN when it is defined for the build.
module tb_fpn_multiplier;

`ifdef FPN_MUL_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_mul;
    logic [7:0] a, b;
    logic       busy, done_mul;
    logic [7:0] product;
    logic [2:0] flags;

    always #5 clk = ~clk;

    fpn_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_mul (start_mul),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done_mul  (done_mul),
        .product   (product),
        .flags     (flags)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] prod;
        logic [2:0] flags;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] prod;
        logic [2:0] flags;
        int         lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic launch(input logic [7:0] ia, input logic [7:0] ib,
                          input logic [7:0] ep, input logic [2:0] ef, input int elat);
        exp_t e;
        e.prod  = ep;
        e.flags = ef;
        e.lat   = elat;
        sb.push_back(e);
        a         = ia;
        b         = ib;
        start_mul = 1'b1;
        @(posedge clk); #1;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int   cyc = 0;
        bit   seen = 1'b0;
        bit   busy_ok = 1'b1;
        exp_t e;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (done_mul === 1'b1) seen = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        e = sb.pop_front();
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no done_mul after %0d cycles, want %0d", tag, cyc, e.lat);
        end else begin
            check({tag, " product"}, 32'(product), 32'(e.prod));
            check({tag, " flags"},   32'(flags),   32'(e.flags));
            check({tag, " latency"}, 32'(cyc),     32'(e.lat));
            check({tag, " busy"},    32'(busy_ok & busy), 32'd1);
        end
    endtask

    task automatic release_start(input string tag);
        start_mul = 1'b0;
        @(posedge clk); #1;
        check({tag, " done cleared"}, 32'(done_mul), 32'd0);
        check({tag, " idle"},         32'(busy),     32'd0);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        launch(v.a, v.b, v.prod, v.flags, v.lat);
        wait_done(tag);
        release_start(tag);
    endtask

    initial begin
        vec_t v;
        bit   quiet;

        vecs.push_back('{8'h38, 8'h38, 8'h38, 3'b000, 4});
        vecs.push_back('{8'h3C, 8'h3C, 8'h41, 3'b000, 4});
        vecs.push_back('{8'h3D, 8'h3D, RNE ? 8'h43 : 8'h42, 3'b000, 4});
        vecs.push_back('{8'h70, 8'h70, 8'h78, 3'b010, 4});
        vecs.push_back('{8'hF0, 8'h70, 8'hF8, 3'b010, 4});
        vecs.push_back('{8'h08, 8'h08, 8'h00, 3'b001, 4});
        vecs.push_back('{8'h88, 8'h08, 8'h80, 3'b001, 4});
        vecs.push_back('{8'h78, 8'h00, 8'hFF, 3'b100, 1});
        vecs.push_back('{8'h79, 8'h38, 8'hFF, 3'b100, 1});
        vecs.push_back('{8'h78, 8'hB8, 8'hF8, 3'b000, 1});
        vecs.push_back('{8'h40, 8'h48, 8'h50, 3'b000, 4});
        vecs.push_back('{8'hB8, 8'h3C, 8'hBC, 3'b000, 4});
        vecs.push_back('{8'h00, 8'hBC, 8'h80, 3'b000, 1});
        vecs.push_back('{8'h05, 8'h38, 8'h00, 3'b000, 1});
        vecs.push_back('{8'hFF, 8'h00, 8'hFF, 3'b100, 1});
        vecs.push_back('{8'h00, 8'hF8, 8'hFF, 3'b100, 1});
        vecs.push_back('{8'h38, 8'h79, 8'hFF, 3'b100, 1});
        vecs.push_back('{8'h39, 8'h3E, RNE ? 8'h40 : 8'h3F, 3'b000, 4});
        vecs.push_back('{8'h3A, 8'h3A, 8'h3C, 3'b000, 4});
        vecs.push_back('{8'h39, 8'h3C, RNE ? 8'h3E : 8'h3D, 3'b000, 4});
        vecs.push_back('{8'h3F, 8'h3F, 8'h46, 3'b000, 4});
        vecs.push_back('{8'h58, 8'h58, 8'h78, 3'b010, 4});
        vecs.push_back('{8'h58, 8'h50, 8'h70, 3'b000, 4});
        vecs.push_back('{8'h20, 8'h18, 8'h00, 3'b001, 4});
        vecs.push_back('{8'h20, 8'h20, 8'h08, 3'b000, 4});

        rst_n     = 1'b0;
        start_mul = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",     32'(busy),     32'd0);
        check("reset done",     32'(done_mul), 32'd0);
        check("reset product",  32'(product),  32'd0);
        check("reset flags",    32'(flags),    32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // start_mul held high through DONE: result must stay put and no new op may start
        launch(8'h3C, 8'h3C, 8'h41, 3'b000, 4);
        wait_done("hold");
        for (int k = 0; k < 10; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
            check("hold done",    32'(done_mul), 32'd1);
            check("hold product", 32'(product),  32'h41);
        end
        release_start("hold");
        @(posedge clk); #1;
        check("hold no restart", 32'(busy), 32'd0);

        // reset while in MUL abandons the op
        a         = 8'h38;
        b         = 8'h38;
        start_mul = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n     = 1'b0;
        start_mul = 1'b0;
        @(posedge clk); #1;
        check("midreset done",    32'(done_mul), 32'd0);
        check("midreset product", 32'(product),  32'd0);
        check("midreset flags",   32'(flags),    32'd0);
        check("midreset busy",    32'(busy),     32'd0);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (done_mul !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("midreset abandoned", 32'(quiet), 32'd1);
        v = '{8'h3D, 8'h3D, RNE ? 8'h43 : 8'h42, 3'b000, 4};
        run_op(v, "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
